hash_table_arbiter: RTL and testbench
=====================================

// Module: hash_table_arbiter
// PURPOSE
//  Shares one hash_table_with_overflow instance between NUM_REQ requesters.
//  Round-robin arbitration; one request in flight. Drives the table's op/key/value port and
//  returns the table's registered result on a shared response channel tagged with requester id.
//  Holds the table at op 2'b11 (no-op) whenever no request is being issued.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2); localparam ID_W = $clog2(NUM_REQ)
//  WIDTH       32  key width, matches hash table WIDTH
//  VALUE_SIZE  32  value width, matches hash table VALUE_SIZE
// PORTS
//  clk           in   1                  single clock, rising edge
//  reset         in   1                  asynchronous, active-high
//  req_valid     in   NUM_REQ            per-requester request valid
//  req_ready     out  NUM_REQ            per-requester accept (one-hot or zero)
//  req_op        in   2*NUM_REQ          op of requester i at [2i+:2]; 00 lookup, 01 insert, 10 delete
//  req_key       in   WIDTH*NUM_REQ      key of requester i at [WIDTH*i+:WIDTH]
//  req_value     in   VALUE_SIZE*NUM_REQ insert value of requester i
//  rsp_valid     out  1                  response valid
//  rsp_ready     in   1                  response consumer ready
//  rsp_id        out  ID_W               index of the requester that owns the response
//  rsp_hit       out  1                  lookup hit (0 for insert/delete)
//  rsp_success   out  1                  op success (lookup: equals hit)
//  rsp_value     out  VALUE_SIZE         lookup value (0 when miss or not a lookup)
//  ht_operation  out  2                  to table operation; 2'b11 when idle
//  ht_key        out  WIDTH              to table key
//  ht_value_in   out  VALUE_SIZE         to table value_in
//  ht_value_out  in   VALUE_SIZE         from table value_out
//  ht_hit        in   1                  from table hit
//  ht_success    in   1                  from table success
//  ops_done      out  16                 count of completed responses, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, ht_operation=2'b11, ht_key=0, ht_value_in=0, rsp_valid=0,
//   rsp_id/hit/success/value=0, ops_done=0. Reset mid-operation abandons the request, no response.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: grant = first i with req_valid[i], searching from rr pointer upward with wrap.
//   req_ready[grant]=1 combinationally in IDLE only; all other req_ready bits=0.
//   Accept when req_valid&req_ready. Latch id, op, key, value; rr pointer <= id+1 (wraps to 0 after NUM_REQ-1).
//   If the latched op is 2'b11: skip the table, go directly to RESP with hit=0, success=0, value=0.
//   Otherwise go to ISSUE.
//  ISSUE (1 cycle): ht_operation/ht_key/ht_value_in registered to the latched op/key/value.
//   The table samples them at the end of this cycle.
//  WAIT (1 cycle): ht_operation back to 2'b11. At the end of this cycle, capture:
//   lookup: rsp_hit=ht_hit, rsp_success=ht_hit, rsp_value=ht_value_out.
//   insert/delete: rsp_hit=0, rsp_value=0, rsp_success=ht_success.
//   Results from earlier ops (the table holds stale hit/success) are never forwarded.
//  RESP: rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready. On that cycle: ops_done+1
//   (saturating), rsp_valid<=0, state->IDLE. No new accept in the same cycle.
//  Latency: accept in cycle T -> ISSUE T+1 -> WAIT T+2 -> rsp_valid high from T+3.
//   Minimum spacing between accepts is 4 cycles.
//  Requesters hold req_valid and payload stable until accepted; deasserting before accept is legal.
//   The arbiter does not latch a request it never granted.
//  No requests: stay in IDLE, ht_operation=2'b11, req_ready=0.
// TESTING
//  T1 reset, then req0 insert key=0x10 val=0xAA -> rsp at T+3: id=0 success=1 hit=0 value=0; ops_done=1.
//  T2 req0 lookup key=0x10 -> id=0 hit=1 success=1 value=0xAA. Lookup key=0x99 -> hit=0 value=0.
//  T3 all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one accept every 4 cycles.
//  T4 rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready all 0, ht_operation stays 2'b11.
//   Then rsp_ready=1 -> completes; the next grant follows the rr pointer.
//  T5 req2 op=2'b11 -> table never sees a non-2'b11 op; rsp id=2 success=0 at T+3.
//  T6 reset asserted during WAIT -> no rsp_valid, ht_operation=2'b11, rr pointer=0, ops_done=0.

Source files
------------

// File: rtl/hash_table_arbiter.sv
// Round-robin arbiter sharing one hash table among NUM_REQ requesters.
// One request is in flight at a time; each result is returned tagged with the owning requester id.
module hash_table_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int VALUE_SIZE = 32,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [WIDTH*NUM_REQ-1:0]      req_key,
  input  logic [VALUE_SIZE*NUM_REQ-1:0] req_value,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_hit,
  output logic                          rsp_success,
  output logic [VALUE_SIZE-1:0]         rsp_value,
  output logic [1:0]                    ht_operation,
  output logic [WIDTH-1:0]              ht_key,
  output logic [VALUE_SIZE-1:0]         ht_value_in,
  input  logic [VALUE_SIZE-1:0]         ht_value_out,
  input  logic                          ht_hit,
  input  logic                          ht_success,
  output logic [15:0]                   ops_done
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_reg;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     id_reg;
  logic [1:0]          op_reg;

  logic                grant_valid;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     rr_ptr_next;
  logic [ID_W:0]       scan_sum;

  logic [1:0]            op_arr  [NUM_REQ];
  logic [WIDTH-1:0]      key_arr [NUM_REQ];
  logic [VALUE_SIZE-1:0] val_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]  = req_op[2*gi +: 2];
      assign key_arr[gi] = req_key[WIDTH*gi +: WIDTH];
      assign val_arr[gi] = req_value[VALUE_SIZE*gi +: VALUE_SIZE];
    end
  endgenerate

  // Scan from the highest offset down so the entry closest to rr_ptr_reg wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid[scan_sum[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = scan_sum[ID_W-1:0];
      end
    end
  end

  assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (state_reg == S_IDLE && grant_valid) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      rr_ptr_reg   <= '0;
      id_reg       <= '0;
      op_reg       <= OP_NOP;
      ht_operation <= OP_NOP;
      ht_key       <= '0;
      ht_value_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_hit      <= 1'b0;
      rsp_success  <= 1'b0;
      rsp_value    <= '0;
      ops_done     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            id_reg     <= grant_id;
            op_reg     <= op_arr[grant_id];
            rr_ptr_reg <= rr_ptr_next;
            if (op_arr[grant_id] == OP_NOP) begin
              // A no-op request never touches the table.
              state_reg   <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_id      <= grant_id;
              rsp_hit     <= 1'b0;
              rsp_success <= 1'b0;
              rsp_value   <= '0;
            end else begin
              state_reg    <= S_ISSUE;
              ht_operation <= op_arr[grant_id];
              ht_key       <= key_arr[grant_id];
              ht_value_in  <= val_arr[grant_id];
            end
          end
        end
        S_ISSUE: begin
          ht_operation <= OP_NOP;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          // The table's registered result for our op is valid during this cycle.
          rsp_valid <= 1'b1;
          rsp_id    <= id_reg;
          if (op_reg == OP_LOOKUP) begin
            rsp_hit     <= ht_hit;
            rsp_success <= ht_hit;
            rsp_value   <= ht_value_out;
          end else begin
            rsp_hit     <= 1'b0;
            rsp_success <= ht_success;
            rsp_value   <= '0;
          end
          state_reg <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (ops_done != 16'hFFFF) begin
              ops_done <= ops_done + 16'd1;
            end
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Bench for hash_table_arbiter: behavioural dictionary/arbiter model checked every cycle,
// a stub hash table with stale registered outputs, and directed scenarios with literal expectations.
module tb_hash_table_arbiter;

  localparam int NUM_REQ = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [7:0]   req_op = '0;
  logic [127:0] req_key = '0;
  logic [127:0] req_value = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic         rsp_hit;
  logic         rsp_success;
  logic [31:0]  rsp_value;
  logic [1:0]   ht_operation;
  logic [31:0]  ht_key;
  logic [31:0]  ht_value_in;
  logic [31:0]  ht_value_out = '0;
  logic         ht_hit = 1'b0;
  logic         ht_success = 1'b0;
  logic [15:0]  ops_done;

  hash_table_arbiter #(.NUM_REQ(4), .WIDTH(32), .VALUE_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_hit(rsp_hit), .rsp_success(rsp_success), .rsp_value(rsp_value),
    .ht_operation(ht_operation), .ht_key(ht_key), .ht_value_in(ht_value_in),
    .ht_value_out(ht_value_out), .ht_hit(ht_hit), .ht_success(ht_success),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stub hash table: registered outputs, stale between ops, garbage value_out on insert.
  logic [31:0] tbl [logic [31:0]];
  int tbl_ops = 0;
  initial begin
    forever begin
      @(posedge clk);
      if (ht_operation != 2'b11) begin
        tbl_ops++;
        case (ht_operation)
          2'b00: begin
            ht_hit       <= tbl.exists(ht_key);
            ht_success   <= tbl.exists(ht_key);
            ht_value_out <= tbl.exists(ht_key) ? tbl[ht_key] : 32'h0;
          end
          2'b01: begin
            tbl[ht_key]  = ht_value_in;
            ht_success   <= 1'b1;
            ht_value_out <= 32'hDEAD_BEEF;
          end
          default: begin
            ht_success <= tbl.exists(ht_key);
            ht_hit     <= 1'b0;
            if (tbl.exists(ht_key)) tbl.delete(ht_key);
          end
        endcase
      end
    end
  end

  // Reference model: dictionary semantics plus round-robin grant and fixed latency.
  logic [31:0] gold [logic [31:0]];
  int          m_cnt = 0;
  bit          m_resp = 0;
  int          m_ptr = 0;
  int          m_ops = 0;
  logic [1:0]  m_op;
  logic [31:0] m_key, m_val;
  int          e_id;
  bit          e_hit, e_succ;
  logic [31:0] e_val;
  int          cyc = 0;
  int          acc_log[$];
  int          acc_cycle[$];

  function automatic int first_grant(input int ptr, input logic [3:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr + k) % NUM_REQ;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_cnt = 0; m_resp = 0; m_ptr = 0; m_ops = 0;
      end else begin
        cyc++;
        if (m_resp) begin
          if (rsp_ready) begin
            m_resp = 0;
            if (m_ops != 16'hFFFF) m_ops++;
          end
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) m_resp = 1;
        end else if (req_valid != 4'b0) begin
          int g;
          g = first_grant(m_ptr, req_valid);
          m_op  = req_op[2*g +: 2];
          m_key = req_key[32*g +: 32];
          m_val = req_value[32*g +: 32];
          e_id = g; e_hit = 0; e_succ = 0; e_val = 0;
          case (m_op)
            2'b00: begin
              e_hit = gold.exists(m_key); e_succ = e_hit;
              e_val = e_hit ? gold[m_key] : 32'h0;
            end
            2'b01: begin gold[m_key] = m_val; e_succ = 1; end
            2'b10: begin
              e_succ = gold.exists(m_key);
              if (e_succ) gold.delete(m_key);
            end
            default: ;
          endcase
          acc_log.push_back(g);
          acc_cycle.push_back(cyc);
          m_ptr = (g + 1) % NUM_REQ;
          if (m_op == 2'b11) m_resp = 1;
          else m_cnt = 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      logic [3:0] exp_ready;
      int g;
      @(negedge clk);
      exp_ready = 4'b0;
      g = first_grant(m_ptr, req_valid);
      if (!m_resp && m_cnt == 0 && g >= 0) exp_ready = 4'b1 << g;
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, m_resp);
      chk("ops_done", ops_done, m_ops[15:0]);
      chk("ht_operation", ht_operation, (m_cnt == 2) ? m_op : 2'b11);
      if (m_cnt == 2) begin
        chk("ht_key", ht_key, m_key);
        chk("ht_value_in", ht_value_in, m_val);
      end
      if (m_resp) begin
        chk("rsp_id", rsp_id, e_id[1:0]);
        chk("rsp_hit", rsp_hit, e_hit);
        chk("rsp_success", rsp_success, e_succ);
        chk("rsp_value", rsp_value, e_val);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] key, input logic [31:0] val);
    req_op[2*i +: 2]     = op;
    req_key[32*i +: 32]  = key;
    req_value[32*i +: 32] = val;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_accept(input int target);
    int k;
    k = 0;
    while (acc_log.size() < target && k < 60) begin
      step(1);
      k++;
    end
    chk("accept_within_budget", acc_log.size() >= target, 1);
  endtask

  task automatic lit_rsp(input int id, input bit hit, input bit succ, input logic [31:0] val);
    chk("lit_rsp_valid", rsp_valid, 1);
    chk("lit_rsp_id", rsp_id, id[1:0]);
    chk("lit_rsp_hit", rsp_hit, hit);
    chk("lit_rsp_success", rsp_success, succ);
    chk("lit_rsp_value", rsp_value, val);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int base, n_tbl;
    // T1: reset state, then insert from requester 0
    #1 reset = 1'b1;
    step(2);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ht_operation", ht_operation, 2'b11);
    chk("rst_ht_key", ht_key, 0);
    chk("rst_ht_value_in", ht_value_in, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    step(1);
    rsp_ready = 1'b1;
    set_req(0, 2'b01, 32'h10, 32'hAA);
    wait_accept(1);
    req_valid = '0;
    chk("t1_issue_op", ht_operation, 2'b01);
    chk("t1_issue_key", ht_key, 32'h10);
    chk("t1_issue_val", ht_value_in, 32'hAA);
    step(2);
    lit_rsp(0, 0, 1, 32'h0);
    step(1);
    chk("t1_ops_done", ops_done, 1);
    chk("t1_rsp_dropped", rsp_valid, 0);

    // T2: lookup hit, then lookup miss from requester 3
    set_req(0, 2'b00, 32'h10, 32'h0);
    wait_accept(2);
    req_valid = '0;
    step(2);
    lit_rsp(0, 1, 1, 32'hAA);
    step(1);
    set_req(3, 2'b00, 32'h99, 32'h0);
    wait_accept(3);
    req_valid = '0;
    step(2);
    lit_rsp(3, 0, 0, 32'h0);
    step(1);
    chk("t2_ops_done", ops_done, 3);

    // T3: all requesters valid continuously
    base = acc_log.size();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 32'h10, 32'h0);
    wait_accept(base + 5);
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      if (acc_log.size() > base + k) chk("t3_grant_order", acc_log[base + k], exp_order[k]);
      if (k > 0 && acc_cycle.size() > base + k)
        chk("t3_accept_spacing", acc_cycle[base + k] - acc_cycle[base + k - 1], 4);
    end
    step(4);

    // T4: response back-pressure, then grant follows the pointer
    rsp_ready = 1'b0;
    set_req(3, 2'b01, 32'h30, 32'h33);
    wait_accept(base + 6);
    req_valid = '0;
    step(2);
    lit_rsp(3, 0, 1, 32'h0);
    set_req(1, 2'b00, 32'h30, 32'h0);
    set_req(2, 2'b10, 32'h10, 32'h0);
    step(10);
    chk("t4_stall_id", rsp_id, 3);
    chk("t4_stall_ready", req_ready, 0);
    chk("t4_stall_htop", ht_operation, 2'b11);
    rsp_ready = 1'b1;
    wait_accept(base + 7);
    req_valid[1] = 1'b0;
    chk("t4_next_grant", acc_log[acc_log.size() - 1], 1);
    step(2);
    lit_rsp(1, 1, 1, 32'h33);
    wait_accept(base + 8);
    req_valid = '0;
    step(2);
    lit_rsp(2, 0, 1, 32'h0);
    step(1);
    // leave a stale hit in the table before the no-op request
    set_req(0, 2'b00, 32'h30, 32'h0);
    wait_accept(base + 9);
    req_valid = '0;
    step(2);
    lit_rsp(0, 1, 1, 32'h33);
    step(1);

    // T5: no-op request bypasses the table
    rsp_ready = 1'b0;
    n_tbl = tbl_ops;
    set_req(2, 2'b11, 32'h30, 32'h55);
    wait_accept(base + 10);
    req_valid = '0;
    step(2);
    lit_rsp(2, 0, 0, 32'h0);
    chk("t5_table_untouched", tbl_ops, n_tbl);
    rsp_ready = 1'b1;
    step(2);

    // T6: reset while the table op is in flight
    set_req(2, 2'b01, 32'h40, 32'h44);
    wait_accept(base + 11);
    req_valid = '0;
    step(1);
    reset = 1'b1;
    #1;
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_htop", ht_operation, 2'b11);
    chk("t6_ops_done", ops_done, 0);
    step(2);
    chk("t6_rsp_valid_held", rsp_valid, 0);
    reset = 1'b0;
    set_req(3, 2'b00, 32'h40, 32'h0);
    set_req(0, 2'b00, 32'h40, 32'h0);
    wait_accept(base + 12);
    req_valid = '0;
    chk("t6_ptr_reset_grant", acc_log[acc_log.size() - 1], 0);
    step(2);
    lit_rsp(0, 1, 1, 32'h44);
    step(3);
    chk("t6_ops_done_after", ops_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
